galaxian_input_ctrl: RTL



---
 rtl/galaxian_input_ctrl_pkg.sv | 56 +++++
 rtl/galaxian_input_ctrl_if.sv | 23 ++
 rtl/galaxian_input_ctrl_coin_pulse_gen.sv | 92 +++++++++
 rtl/galaxian_input_ctrl.sv | 98 +++++++++
 4 files changed

// File: rtl/galaxian_input_ctrl_pkg.sv
// Shared constants for the Galaxian input conditioning stage: PS/2 set-2 scancodes,
// joystick bit positions, the held-key latch record and the coin FSM states.
package galaxian_input_pkg;

  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_CTRL  = 8'h14;
  localparam logic [7:0] SC_F1    = 8'h05;
  localparam logic [7:0] SC_F2    = 8'h06;
  localparam logic [7:0] SC_1     = 8'h16;
  localparam logic [7:0] SC_2     = 8'h1E;
  localparam logic [7:0] SC_5     = 8'h2E;
  localparam logic [7:0] SC_6     = 8'h36;
  localparam logic [7:0] SC_R     = 8'h2D;
  localparam logic [7:0] SC_F     = 8'h2B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_G     = 8'h34;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_T     = 8'h2C;

  localparam int JOY_RIGHT  = 0;
  localparam int JOY_LEFT   = 1;
  localparam int JOY_DOWN   = 2;
  localparam int JOY_UP     = 3;
  localparam int JOY_FIRE   = 4;
  localparam int JOY_START1 = 5;
  localparam int JOY_START2 = 6;
  localparam int JOY_COIN   = 7;

  typedef enum logic [1:0] {IDLE, PULSE, GAP} coin_state_t;

  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
    logic space;
    logic ctrl;
    logic f1;
    logic one;
    logic f2;
    logic two;
    logic five;
    logic six;
    logic p2_up;
    logic p2_down;
    logic p2_left;
    logic p2_right;
    logic p2_fire;
    logic test;
  } key_latch_t;

endpackage

// File: rtl/galaxian_input_ctrl_if.sv
// Bundle of raw controller inputs and conditioned button outputs between the
// input stage and the core's switch-port packing.
interface galaxian_input_ctrl_if;
  logic [10:0] ps2_key;
  logic [15:0] joy;
  logic [4:0]  p1;
  logic [4:0]  p2;
  logic        start1;
  logic        start2;
  logic        coin;
  logic        test;
  logic        coin_busy;

  modport master (
    output ps2_key, joy,
    input  p1, p2, start1, start2, coin, test, coin_busy
  );

  modport slave (
    input  ps2_key, joy,
    output p1, p2, start1, start2, coin, test, coin_busy
  );
endinterface

// File: rtl/galaxian_input_ctrl_coin_pulse_gen.sv
// Turns coin request edges into fixed-width, fixed-gap pulses, queueing up to
// COIN_QMAX extra requests so the polled Z80 coin routine sees every coin once.
module coin_pulse_gen
  import galaxian_input_pkg::*;
#(
  parameter int COIN_PULSE = 1200000,
  parameter int COIN_GAP   = 1200000,
  parameter int COIN_QMAX  = 3
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic coin_raw,
  output logic coin,
  output logic coin_busy
);

  localparam int CNT_MAX = (COIN_PULSE > COIN_GAP) ? COIN_PULSE : COIN_GAP;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int PW      = $clog2(COIN_QMAX + 1);

  coin_state_t   state;
  logic [CW-1:0] cnt;
  logic [PW-1:0] pend;
  logic [PW-1:0] pend_nxt;
  logic          raw_q;
  logic          req;
  logic          to_pulse;
  logic          idle_nxt;

  assign req = coin_raw & ~raw_q;

  always_comb begin
    to_pulse = 1'b0;
    case (state)
      IDLE:    to_pulse = (pend != '0) || req;
      GAP:     to_pulse = (cnt == '0) && (pend != '0);
      default: to_pulse = 1'b0;
    endcase

    idle_nxt = !to_pulse && ((state == IDLE) || ((state == GAP) && (cnt == '0)));

    // A request consumed in the same cycle it launches a pulse leaves pend as is.
    pend_nxt = pend;
    if (req && !to_pulse && (pend != PW'(COIN_QMAX)))
      pend_nxt = pend + PW'(1);
    else if (!req && to_pulse)
      pend_nxt = pend - PW'(1);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      pend      <= '0;
      coin      <= 1'b0;
      coin_busy <= 1'b0;
      // NOTE: reset to 1 so a coin held through reset is not seen as a new edge.
      raw_q     <= 1'b1;
    end else begin
      raw_q     <= coin_raw;
      pend      <= pend_nxt;
      coin_busy <= !idle_nxt || (pend_nxt != '0);
      if (to_pulse) begin
        state <= PULSE;
        cnt   <= CW'(COIN_PULSE - 1);
        coin  <= 1'b1;
      end else begin
        case (state)
          PULSE: begin
            if (cnt == '0) begin
              state <= GAP;
              cnt   <= CW'(COIN_GAP - 1);
              coin  <= 1'b0;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          GAP: begin
            if (cnt == '0) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/galaxian_input_ctrl.sv
// Galaxian input conditioning: PS/2 key events become held-button latches, merged
// with the joystick word into registered active-high controls plus a shaped coin.
module galaxian_input_ctrl
  import galaxian_input_pkg::*;
#(
  parameter int COIN_PULSE = 1200000,
  parameter int COIN_GAP   = 1200000,
  parameter int COIN_QMAX  = 3
) (
  input  logic              clk_sys,
  input  logic              reset,
  galaxian_input_ctrl_if.slave io
);

  key_latch_t keys;
  logic       old_tog;
  logic       key_event;
  logic       pressed;
  logic       ext;
  logic [7:0] code;
  logic       coin_raw;
  logic       unused_joy_hi;

  assign pressed       = io.ps2_key[9];
  assign ext           = io.ps2_key[8];
  assign code          = io.ps2_key[7:0];
  assign key_event     = io.ps2_key[10] != old_tog;
  assign unused_joy_hi = ^io.joy[15:8];

  // old_tog tracks the strobe even in reset, so a stale toggle is absorbed.
  always_ff @(posedge clk_sys) begin
    old_tog <= io.ps2_key[10];
    if (reset) begin
      keys <= '0;
    end else if (key_event) begin
      case (code)
        SC_UP:    keys.up    <= pressed;
        SC_DOWN:  keys.down  <= pressed;
        SC_LEFT:  keys.left  <= pressed;
        SC_RIGHT: keys.right <= pressed;
        default: begin
          if (!ext) begin
            case (code)
              SC_SPACE: keys.space    <= pressed;
              SC_CTRL:  keys.ctrl     <= pressed;
              SC_F1:    keys.f1       <= pressed;
              SC_1:     keys.one      <= pressed;
              SC_F2:    keys.f2       <= pressed;
              SC_2:     keys.two      <= pressed;
              SC_5:     keys.five     <= pressed;
              SC_6:     keys.six      <= pressed;
              SC_R:     keys.p2_up    <= pressed;
              SC_F:     keys.p2_down  <= pressed;
              SC_D:     keys.p2_left  <= pressed;
              SC_G:     keys.p2_right <= pressed;
              SC_A:     keys.p2_fire  <= pressed;
              SC_T:     keys.test     <= pressed;
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      io.p1     <= '0;
      io.p2     <= '0;
      io.start1 <= 1'b0;
      io.start2 <= 1'b0;
      io.test   <= 1'b0;
    end else begin
      io.p1     <= {keys.space | keys.ctrl, keys.up, keys.down, keys.left, keys.right}
                   | io.joy[JOY_FIRE:JOY_RIGHT];
      io.p2     <= {keys.p2_fire, keys.p2_up, keys.p2_down, keys.p2_left, keys.p2_right}
                   | io.joy[JOY_FIRE:JOY_RIGHT];
      io.start1 <= keys.f1 | keys.one | io.joy[JOY_START1];
      io.start2 <= keys.f2 | keys.two | io.joy[JOY_START2];
      io.test   <= keys.test;
    end
  end

  assign coin_raw = keys.five | keys.six | io.joy[JOY_COIN];

  coin_pulse_gen #(
    .COIN_PULSE (COIN_PULSE),
    .COIN_GAP   (COIN_GAP),
    .COIN_QMAX  (COIN_QMAX)
  ) u_coin (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .coin_raw  (coin_raw),
    .coin      (io.coin),
    .coin_busy (io.coin_busy)
  );

endmodule
